handle_leak_tracker: RTL and testbench
======================================

HANDLE_LEAK_TRACKER -- requirements
Module: handle_leak_tracker

Interface
REQ-001 Parameter NUM_HANDLES, default 8, size of the handle pool (2..64).
REQ-002 Parameter AGE_W, default 8, width of each per-handle age counter.
REQ-003 Parameter LEAK_LIMIT, default 200, age in cycles at which a live handle is declared leaked (1..2**AGE_W-1).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 alloc_req  in  1  request a new handle.
REQ-008 alloc_gnt  out  1  one-cycle pulse: handle granted.
REQ-009 alloc_fail  out  1  one-cycle pulse: pool full, request dropped.
REQ-010 alloc_id  out  ID_W  granted handle id, valid with alloc_gnt.
REQ-011 free_req  in  1  release a handle.
REQ-012 free_id  in  ID_W  handle being released.
REQ-013 free_err  out  1  one-cycle pulse: free of a non-live id (double free).
REQ-014 live_count  out  ID_W+1  number of live handles.
REQ-015 peak_count  out  ID_W+1  highest live_count since reset.
REQ-016 leak_mask  out  NUM_HANDLES  sticky per-handle leaked flags.
REQ-017 leak_event  out  1  one-cycle pulse: at least one handle newly leaked this cycle.
REQ-018 audit_req  in  1  start an end-of-test audit sweep.
REQ-019 audit_valid  out  1  audit reports a live handle this cycle.
REQ-020 audit_id  out  ID_W  id reported, valid with audit_valid.
REQ-021 audit_done  out  1  one-cycle pulse after the last id is visited.
REQ-022 audit_busy  out  1  high while the sweep runs.

Function
REQ-023 ID_W = $clog2(NUM_HANDLES); all outputs registered; response latency 1 cycle after the request edge.
REQ-024 Allocation grants the lowest-index free slot, marks it live, and clears its age and leak flag.
REQ-025 alloc_req with all slots live -> alloc_fail pulse; state unchanged.
REQ-026 free_req on a live id clears live, age and leak_mask bit; on a non-live id -> free_err pulse, no state change.
REQ-027 Simultaneous alloc and free: both are evaluated against pre-cycle state; the slot freed this cycle is not grantable until the next cycle; live_count nets +1 -1 = unchanged.
REQ-028 Simultaneous alloc and free with a full pool: free succeeds, alloc_fail pulses.
REQ-029 Each live slot age increments every cycle and saturates at 2**AGE_W-1; free slots hold age 0.
REQ-030 A slot whose age reaches LEAK_LIMIT sets its leak_mask bit; leak_event pulses in that same cycle; no re-pulse while the bit stays set.
REQ-031 peak_count updates whenever live_count exceeds it; never decreases except on reset.
REQ-032 Audit FSM states: IDLE, SCAN, DONE. IDLE -> SCAN on audit_req; SCAN visits one id per cycle, 0..NUM_HANDLES-1, asserting audit_valid with audit_id when that slot is live at its visit cycle; SCAN -> DONE after the last id; DONE pulses audit_done for one cycle -> IDLE.
REQ-033 audit_req while audit_busy is ignored; alloc and free stay fully operational during a sweep.

Reset
REQ-034 rst clears all slots to free, ages to 0, leak_mask to 0, live_count and peak_count to 0, all pulse outputs to 0, audit FSM to IDLE, alloc_id and audit_id to 0.
REQ-035 rst has priority over every concurrent request; requests in the rst cycle are discarded.
REQ-036 rst during SCAN aborts the sweep with no audit_done.

Structure
REQ-037 Package leak_tracker_pkg holds the audit state enum and default parameter constants.
REQ-038 One sub-module, leak_priority_encoder, finds the lowest free index and a found flag.

Verification
REQ-039 Reset, 3 allocs, 3 frees -> ids 0,1,2; live_count 3 then 0; peak_count 3; no leak_event.
REQ-040 NUM_HANDLES=8: 9 allocs -> ids 0..7 granted, 9th gives alloc_fail; live_count 8.
REQ-041 Free id 5 twice -> first clears, second pulses free_err; live_count drops by exactly 1.
REQ-042 LEAK_LIMIT=20: alloc id 0, idle 20 cycles -> leak_mask[0]=1, single leak_event; free id 0 -> mask bit cleared.
REQ-043 Pool full, same-cycle free id 3 and alloc -> alloc_fail; next-cycle alloc grants id 3.
REQ-044 Live ids {1,4}, audit_req -> audit_valid with ids 1 and 4 only, audit_done 8 cycles after SCAN entry.

Source files
------------

// File: rtl/leak_tracker_pkg.sv
// rtl/leak_tracker_pkg.sv - shared audit state type and default parameters for the handle leak tracker
package leak_tracker_pkg;

   localparam int DEF_NUM_HANDLES = 8;
   localparam int DEF_AGE_W       = 8;
   localparam int DEF_LEAK_LIMIT  = 200;

   typedef enum logic [1:0] {
      AUDIT_IDLE = 2'd0,
      AUDIT_SCAN = 2'd1,
      AUDIT_DONE = 2'd2
   } audit_state_t;

endpackage

// File: rtl/leak_priority_encoder.sv
// rtl/leak_priority_encoder.sv - lowest-set-bit finder used to pick the next free handle slot
module leak_priority_encoder #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     req,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // scan from the top down so the lowest set bit is the last one written
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/handle_leak_tracker.sv
// rtl/handle_leak_tracker.sv - handle pool allocator with per-handle aging, leak flags and audit sweep
module handle_leak_tracker
   import leak_tracker_pkg::*;
#(
   parameter int NUM_HANDLES = DEF_NUM_HANDLES,
   parameter int AGE_W       = DEF_AGE_W,
   parameter int LEAK_LIMIT  = DEF_LEAK_LIMIT,
   localparam int ID_W       = $clog2(NUM_HANDLES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   alloc_req,
   output logic                   alloc_gnt,
   output logic                   alloc_fail,
   output logic [ID_W-1:0]        alloc_id,
   input  logic                   free_req,
   input  logic [ID_W-1:0]        free_id,
   output logic                   free_err,
   output logic [ID_W:0]          live_count,
   output logic [ID_W:0]          peak_count,
   output logic [NUM_HANDLES-1:0] leak_mask,
   output logic                   leak_event,
   input  logic                   audit_req,
   output logic                   audit_valid,
   output logic [ID_W-1:0]        audit_id,
   output logic                   audit_done,
   output logic                   audit_busy
);

   localparam logic [AGE_W-1:0] AGE_MAX   = '1;
   localparam logic [AGE_W-1:0] LEAK_AGE  = AGE_W'(LEAK_LIMIT);

   logic [NUM_HANDLES-1:0] live;
   logic [NUM_HANDLES-1:0] live_nxt;
   logic [NUM_HANDLES-1:0] leak_nxt;
   logic [NUM_HANDLES-1:0] set_mask;
   logic [NUM_HANDLES-1:0] grant_oh;
   logic [NUM_HANDLES-1:0] free_oh;
   logic [AGE_W-1:0]       age     [NUM_HANDLES];
   logic [AGE_W-1:0]       age_nxt [NUM_HANDLES];
   logic [ID_W-1:0]        free_idx;
   logic                   free_found;
   logic                   free_ok;
   logic                   grant;
   logic [ID_W:0]          count_nxt;
   logic [ID_W-1:0]        scan_idx;
   audit_state_t           state;
   audit_state_t           state_nxt;

   leak_priority_encoder #(
      .N     (NUM_HANDLES),
      .IDX_W (ID_W)
   ) u_free_enc (
      .req   (~live),
      .idx   (free_idx),
      .found (free_found)
   );

   // alloc and free both judged against pre-cycle live state, so a slot freed now cannot be granted now
   always_comb begin
      free_ok  = 1'b0;
      grant_oh = '0;
      free_oh  = '0;
      if (free_req && (int'(free_id) < NUM_HANDLES)) begin
         free_ok = live[free_id];
      end
      grant = alloc_req && free_found;
      if (grant) begin
         grant_oh[free_idx] = 1'b1;
      end
      if (free_ok) begin
         free_oh[free_id] = 1'b1;
      end
      live_nxt  = (live | grant_oh) & ~free_oh;
      count_nxt = '0;
      for (int i = 0; i < NUM_HANDLES; i++) begin
         count_nxt = count_nxt + (ID_W + 1)'(live_nxt[i]);
      end
   end

   // ages run only on slots that stay live; crossing the limit raises a leak flag exactly once
   always_comb begin
      set_mask = '0;
      for (int i = 0; i < NUM_HANDLES; i++) begin
         if (!live[i] || grant_oh[i] || free_oh[i]) begin
            age_nxt[i] = '0;
         end else begin
            age_nxt[i] = (age[i] == AGE_MAX) ? age[i] : age[i] + 1'b1;
            set_mask[i] = (age_nxt[i] >= LEAK_AGE) && !leak_mask[i];
         end
      end
      leak_nxt = (leak_mask & ~(grant_oh | free_oh)) | set_mask;
   end

   // audit sweep sequencing: one id per cycle, then a single DONE cycle
   always_comb begin
      state_nxt = state;
      case (state)
         AUDIT_IDLE: if (audit_req) state_nxt = AUDIT_SCAN;
         AUDIT_SCAN: if (int'(scan_idx) == NUM_HANDLES - 1) state_nxt = AUDIT_DONE;
         AUDIT_DONE: state_nxt = AUDIT_IDLE;
         default:    state_nxt = AUDIT_IDLE;
      endcase
   end

   // pool state, ages, counters and allocation/free responses
   always_ff @(posedge clk) begin
      if (rst) begin
         live       <= '0;
         leak_mask  <= '0;
         leak_event <= 1'b0;
         alloc_gnt  <= 1'b0;
         alloc_fail <= 1'b0;
         alloc_id   <= '0;
         free_err   <= 1'b0;
         live_count <= '0;
         peak_count <= '0;
         for (int i = 0; i < NUM_HANDLES; i++) begin
            age[i] <= '0;
         end
      end else begin
         live       <= live_nxt;
         leak_mask  <= leak_nxt;
         leak_event <= |set_mask;
         alloc_gnt  <= grant;
         alloc_fail <= alloc_req && !free_found;
         free_err   <= free_req && !free_ok;
         live_count <= count_nxt;
         if (grant) begin
            alloc_id <= free_idx;
         end
         if (count_nxt > peak_count) begin
            peak_count <= count_nxt;
         end
         for (int i = 0; i < NUM_HANDLES; i++) begin
            age[i] <= age_nxt[i];
         end
      end
   end

   // audit FSM and its registered report outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= AUDIT_IDLE;
         scan_idx    <= '0;
         audit_valid <= 1'b0;
         audit_id    <= '0;
         audit_done  <= 1'b0;
         audit_busy  <= 1'b0;
      end else begin
         state       <= state_nxt;
         audit_busy  <= (state_nxt != AUDIT_IDLE);
         audit_done  <= (state_nxt == AUDIT_DONE);
         audit_valid <= (state == AUDIT_SCAN) && live[scan_idx];
         if (state == AUDIT_SCAN) begin
            audit_id <= scan_idx;
            scan_idx <= scan_idx + 1'b1;
         end else begin
            scan_idx <= '0;
         end
      end
   end

endmodule

// File: tb/tb_handle_leak_tracker.sv
// tb/tb_handle_leak_tracker.sv - scoreboard bench for handle_leak_tracker
module tb_handle_leak_tracker;

   localparam int N    = 8;
   localparam int AW   = 8;
   localparam int LIM  = 20;
   localparam int IW   = 3;
   localparam int AMAX = 255;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          alloc_req = 1'b0;
   logic          alloc_gnt;
   logic          alloc_fail;
   logic [IW-1:0] alloc_id;
   logic          free_req = 1'b0;
   logic [IW-1:0] free_id = '0;
   logic          free_err;
   logic [IW:0]   live_count;
   logic [IW:0]   peak_count;
   logic [N-1:0]  leak_mask;
   logic          leak_event;
   logic          audit_req = 1'b0;
   logic          audit_valid;
   logic [IW-1:0] audit_id;
   logic          audit_done;
   logic          audit_busy;

   handle_leak_tracker #(
      .NUM_HANDLES (N),
      .AGE_W       (AW),
      .LEAK_LIMIT  (LIM)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .alloc_req   (alloc_req),
      .alloc_gnt   (alloc_gnt),
      .alloc_fail  (alloc_fail),
      .alloc_id    (alloc_id),
      .free_req    (free_req),
      .free_id     (free_id),
      .free_err    (free_err),
      .live_count  (live_count),
      .peak_count  (peak_count),
      .leak_mask   (leak_mask),
      .leak_event  (leak_event),
      .audit_req   (audit_req),
      .audit_valid (audit_valid),
      .audit_id    (audit_id),
      .audit_done  (audit_done),
      .audit_busy  (audit_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int gnt;
      int fail;
      int aid;
      int ferr;
      int cnt;
      int peak;
      int mask;
      int lev;
      int av;
      int audid;
      int adone;
      int abusy;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   bit m_live [N];
   int m_age  [N];
   bit m_leak [N];
   int m_peak, m_alloc_id, m_audit_id, m_state, m_idx;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // drive one cycle of stimulus, predict outputs, then compare after the edge
   task automatic step(input bit r, input bit a, input bit f, input int fid, input bit au);
      exp_t e;
      bit   pre_live [N];
      int   low;
      bit   fok;
      int   cnt;
      rst       = r;
      alloc_req = a;
      free_req  = f;
      free_id   = IW'(fid);
      audit_req = au;
      e = '{default: 0};
      if (r) begin
         for (int i = 0; i < N; i++) begin
            m_live[i] = 0; m_age[i] = 0; m_leak[i] = 0;
         end
         m_peak = 0; m_alloc_id = 0; m_audit_id = 0; m_state = 0; m_idx = 0;
      end else begin
         for (int i = 0; i < N; i++) pre_live[i] = m_live[i];
         low = -1;
         for (int i = 0; i < N; i++) if (!m_live[i] && low < 0) low = i;
         fok = f && (fid < N) && m_live[fid];
         e.ferr = (f && !fok) ? 1 : 0;
         e.gnt  = (a && low >= 0) ? 1 : 0;
         e.fail = (a && low < 0) ? 1 : 0;
         for (int i = 0; i < N; i++) begin
            if (m_live[i] && !(fok && i == fid)) begin
               if (m_age[i] < AMAX) m_age[i]++;
               if (m_age[i] >= LIM && !m_leak[i]) begin
                  m_leak[i] = 1;
                  e.lev = 1;
               end
            end
         end
         if (fok) begin
            m_live[fid] = 0; m_age[fid] = 0; m_leak[fid] = 0;
         end
         if (e.gnt == 1) begin
            m_live[low] = 1; m_age[low] = 0; m_leak[low] = 0; m_alloc_id = low;
         end
         case (m_state)
            0: if (au) begin m_state = 1; m_idx = 0; end
            1: begin
               e.av = pre_live[m_idx] ? 1 : 0;
               m_audit_id = m_idx;
               if (m_idx == N - 1) m_state = 2;
               m_idx++;
            end
            default: m_state = 0;
         endcase
      end
      cnt = 0;
      for (int i = 0; i < N; i++) begin
         cnt += m_live[i] ? 1 : 0;
         if (m_leak[i]) e.mask |= (1 << i);
      end
      if (cnt > m_peak) m_peak = cnt;
      e.cnt   = cnt;
      e.peak  = m_peak;
      e.aid   = m_alloc_id;
      e.audid = m_audit_id;
      e.adone = (m_state == 2) ? 1 : 0;
      e.abusy = (m_state != 0) ? 1 : 0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("alloc_gnt",   int'(alloc_gnt),   e.gnt);
      chk("alloc_fail",  int'(alloc_fail),  e.fail);
      chk("alloc_id",    int'(alloc_id),    e.aid);
      chk("free_err",    int'(free_err),    e.ferr);
      chk("live_count",  int'(live_count),  e.cnt);
      chk("peak_count",  int'(peak_count),  e.peak);
      chk("leak_mask",   int'(leak_mask),   e.mask);
      chk("leak_event",  int'(leak_event),  e.lev);
      chk("audit_valid", int'(audit_valid), e.av);
      chk("audit_id",    int'(audit_id),    e.audid);
      chk("audit_done",  int'(audit_done),  e.adone);
      chk("audit_busy",  int'(audit_busy),  e.abusy);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   int leak_pulses;

   initial begin
      #2;
      step(1, 0, 0, 0, 0);
      step(1, 1, 1, 2, 1);

      // three allocs then three frees
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, i, 0);
      idle(2);

      // fill the pool and overflow once
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0);
      // full pool: simultaneous free of 3 and alloc, then alloc gets 3
      step(0, 1, 1, 3, 0);
      step(0, 1, 0, 0, 0);
      // double free of id 5
      step(0, 0, 1, 5, 0);
      step(0, 0, 1, 5, 0);
      idle(2);

      // leak detection on id 0
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      leak_pulses = 0;
      for (int i = 0; i < 22; i++) begin
         step(0, 0, 0, 0, 0);
         leak_pulses += int'(leak_event);
      end
      chk("single_leak_pulse", leak_pulses, 1);
      step(0, 0, 1, 0, 0);
      idle(2);

      // audit with live ids {1,4}; a second request during the sweep is ignored
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 2, 0);
      step(0, 0, 1, 3, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      idle(11);

      // reset in the middle of a sweep
      step(0, 0, 0, 0, 1);
      idle(3);
      step(1, 0, 0, 0, 0);
      idle(10);

      // random traffic, long enough for ages to saturate
      for (int i = 0; i < 700; i++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 4) == 0),
              int'($urandom_range(0, N - 1)),
              ($urandom_range(0, 15) == 0));
      end

      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
